// File: rtl/alu_seq_mul.sv
// alu_seq_mul: single-issue ALU with a sequential unsigned multiplier.
//
// One request is accepted at a time through a valid/ready handshake. Most
// opcodes complete at the accepting edge. MULU (opcode 12) instead runs a
// shift-add multiplier that retires one multiplier bit per cycle for WIDTH
// cycles. The result is held until the consumer takes it.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : synchronous active-high reset
//   in_valid   : request present
//   in_ready   : block accepts a request this cycle (IDLE only)
//   operand1   : operand A
//   operand2   : operand B; bits [SHW-1:0] are the shift amount for shifts
//   opcode     : operation select (0..15)
//   out_valid  : result registers hold a completed result (HOLD only)
//   out_ready  : consumer takes the result
//   result     : registered WIDTH-bit result
//   carry_out  : registered carry/flag
//   product    : registered full 2*WIDTH-bit product (0 for non-multiply ops)
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    input  logic [3:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out,
    output logic [2*WIDTH-1:0] product
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH:0]     alu_out;

    // Single-cycle operations. Returns {carry_out, result}.
    function automatic logic [WIDTH:0] alu_compute(input logic [3:0]       op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [SHW-1:0] sh;
        logic           lt;
        logic [WIDTH:0] r;
        sh = b[SHW-1:0];
        lt = 1'b0;
        r  = '0;
        case (op)
            4'd0:  r = {1'b0, a} + {1'b0, b};
            4'd1:  r = {(a >= b), a - b};
            4'd2:  r = {1'b0, a & b};
            4'd3:  r = {1'b0, a | b};
            4'd4:  r = {1'b0, a ^ b};
            4'd5:  r = {1'b0, ~(a | b)};
            4'd6:  r = {1'b0, ~a};
            4'd7:  r = {1'b0, a << sh};
            4'd8:  r = {1'b0, a >> sh};
            4'd9:  r = {1'b0, $unsigned($signed(a) >>> sh)};
            4'd10: begin
                lt = ($signed(a) < $signed(b));
                r  = {lt, {(WIDTH-1){1'b0}}, lt};
            end
            4'd11: begin
                lt = (a < b);
                r  = {lt, {(WIDTH-1){1'b0}}, lt};
            end
            4'd13: r = {1'b0, a} + (WIDTH+1)'(1);
            4'd14: r = {(a != '0), a - WIDTH'(1)};
            4'd15: r = {1'b0, b};
            default: r = '0;  // MULU is handled by the sequential path
        endcase
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        carry_d   = carry_q;
        product_d = product_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;

        // acc holds {partial sum, unconsumed multiplier bits}. Each step adds
        // the multiplicand to the upper half when the current LSB is set, then
        // shifts right, pulling the addition carry into the top bit.
        step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        step_acc = {step_sum, acc_q[WIDTH-1:1]};

        alu_out  = alu_compute(opcode, operand1, operand2);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (opcode == 4'd12) begin
                        mcand_d = operand1;
                        acc_d   = {{WIDTH{1'b0}}, operand2};
                        cnt_d   = '0;
                        state_d = MUL;
                    end else begin
                        result_d  = alu_out[WIDTH-1:0];
                        carry_d   = alu_out[WIDTH];
                        product_d = '0;
                        state_d   = HOLD;
                    end
                end
            end
            MUL: begin
                acc_d = step_acc;
                if (cnt_q == SHW'(WIDTH-1)) begin
                    product_d = step_acc;
                    result_d  = step_acc[WIDTH-1:0];
                    carry_d   = |step_acc[2*WIDTH-1:WIDTH];
                    state_d   = HOLD;
                end else begin
                    cnt_d = cnt_q + SHW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            carry_q   <= 1'b0;
            product_q <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign product   = product_q;

endmodule
